delta_run_encoder: RTL

- Compresses a stream of per-neuron deltas into (run, value) tokens: a token means "skip `run` zero deltas, then apply `value`".
- Sits on the producer side of the delta path. Its `out_run` feeds the `count_init` of the downstream delta down-counter, so the counter re-expands each run.
- Removes zero-delta beats from the compute path.

---
 rtl/delta_run_encoder_pkg.sv | 28 ++
 rtl/delta_run_encoder_up_counter.sv | 31 +++
 rtl/delta_run_encoder.sv | 103 ++++++++++
 3 files changed

// File: rtl/delta_run_encoder_pkg.sv
// delta_pkg: shared FSM states, token layout and run-length limits for the delta path.
// DELTA_SIM_LEN sets the run-length field width when sys_defs.svh has not provided it.
`ifndef DELTA_SIM_LEN
`define DELTA_SIM_LEN 8
`endif

package delta_pkg;

  localparam int unsigned DELTA_DATA_W = 16;
  localparam int unsigned DELTA_LEN_W  = `DELTA_SIM_LEN;
  localparam int unsigned RUN_MAX      = (1 << DELTA_LEN_W) - 1;

  typedef enum logic [0:0] {
    S_ACC,
    S_STALL
  } delta_state_e;

  typedef struct packed {
    logic [DELTA_LEN_W-1:0]  run;
    logic [DELTA_DATA_W-1:0] data;
    logic                    last;
  } delta_token_t;

  function automatic int unsigned run_max(input int unsigned len_w);
    return (1 << len_w) - 1;
  endfunction

endpackage

// File: rtl/delta_run_encoder_up_counter.sv
// delta_up_counter: zero-run counter feeding the encoder; mirror of the downstream down-counter.
// o_at_max flags the last count before RUN_MAX so the encoder can emit a saturation token.
module delta_up_counter
  import delta_pkg::*;
#(
  parameter int unsigned LEN_W = DELTA_LEN_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [LEN_W-1:0] o_count,
  output logic             o_at_max
);

  localparam logic [LEN_W-1:0] SAT = LEN_W'(run_max(LEN_W) - 1);

  logic [LEN_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + LEN_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_at_max = (r_count == SAT);

endmodule

// File: rtl/delta_run_encoder.sv
// delta_run_encoder: folds zero deltas into (run, value) tokens behind a one-deep output register.
// Optional DELTA_RUN_STATS_EN adds saturating token / skipped-zero counters.
module delta_run_encoder
  import delta_pkg::*;
#(
  parameter int unsigned DATA_W = DELTA_DATA_W,
  parameter int unsigned LEN_W  = DELTA_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LEN_W-1:0]  out_run,
  output logic [DATA_W-1:0] out_data,
`ifdef DELTA_RUN_STATS_EN
  output logic [31:0]       stat_tokens,
  output logic [31:0]       stat_zeros_skipped,
`endif
  output logic              out_last
);

  delta_state_e     r_state;
  delta_token_t     r_tok;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_xfer;
  logic             w_emit;
  logic             w_inc;
  logic             w_at_max;
  logic [LEN_W-1:0] w_run_cnt;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_out_valid && out_ready;
  // Saturation token carries in_data, which is zero on that path.
  assign w_emit   = w_accept && (in_last || (in_data != '0) || w_at_max);
  assign w_inc    = w_accept && !w_emit;

  delta_up_counter #(
    .LEN_W(LEN_W)
  ) u_run_cnt (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_inc    (w_inc),
    .i_clr    (w_emit),
    .o_count  (w_run_cnt),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_ACC;
      r_out_valid <= 1'b0;
      r_tok       <= '0;
    end else begin
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_tok       <= {w_run_cnt, in_data, in_last};
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_ACC:   if (r_out_valid && !out_ready) r_state <= S_STALL;
        S_STALL: if (out_ready) r_state <= S_ACC;
        default: r_state <= S_ACC;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_run   = r_tok.run;
  assign out_data  = r_tok.data;
  assign out_last  = r_tok.last;

`ifdef DELTA_RUN_STATS_EN
  logic [31:0] r_stat_tokens;
  logic [31:0] r_stat_zeros;
  logic [32:0] w_zero_sum;

  assign w_zero_sum = {1'b0, r_stat_zeros} + 33'(r_tok.run);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_tokens <= '0;
      r_stat_zeros  <= '0;
    end else if (w_xfer) begin
      if (r_stat_tokens != '1) r_stat_tokens <= r_stat_tokens + 32'd1;
      r_stat_zeros <= w_zero_sum[32] ? '1 : w_zero_sum[31:0];
    end
  end

  assign stat_tokens        = r_stat_tokens;
  assign stat_zeros_skipped = r_stat_zeros;
`else
  localparam bit STATS_EN = 1'b0;
`endif

endmodule
